pll_lock_supervisor: RTL

//  Supervises one PolarFire CCC PLL. Drives PLL_POWERDOWN_N, qualifies PLL_LOCK, and releases
//  N_OUT per-output-clock reset lines in a staggered order once lock is stable.

---
 rtl/pll_lock_supervisor.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// ============================================================================
// Module   : pll_lock_supervisor
// Brief    : Sequences one CCC PLL: power-down pulse, lock qualification,
//            staggered per-output reset release, retry/fault, loss counting.
// Revision : 1.0
// ============================================================================
module pll_lock_supervisor #(
   parameter int N_OUT               = 2,
   parameter int POWERDOWN_CYCLES    = 64,
   parameter int LOCK_TIMEOUT_CYCLES = 65535,
   parameter int LOCK_STABLE_CYCLES  = 256,
   parameter int RST_STAGGER_CYCLES  = 16,
   parameter int MAX_RETRIES         = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             pll_lock,
   output logic             pll_powerdown_n,
   output logic [N_OUT-1:0] out_reset_n,
   output logic             ready,
   output logic             fault,
   output logic [7:0]       lock_loss_count,
   output logic [2:0]       state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_PWRDN   = 3'd1,
      S_WAIT    = 3'd2,
      S_STABLE  = 3'd3,
      S_RELEASE = 3'd4,
      S_RUN     = 3'd5,
      S_FAULT   = 3'd6
   } state_t;

   localparam int W_PD  = (POWERDOWN_CYCLES    > 1) ? $clog2(POWERDOWN_CYCLES)    : 1;
   localparam int W_TO  = (LOCK_TIMEOUT_CYCLES > 1) ? $clog2(LOCK_TIMEOUT_CYCLES) : 1;
   localparam int W_ST  = (LOCK_STABLE_CYCLES  > 1) ? $clog2(LOCK_STABLE_CYCLES)  : 1;
   localparam int W_SG  = (RST_STAGGER_CYCLES  > 1) ? $clog2(RST_STAGGER_CYCLES)  : 1;
   localparam int W_A   = (W_PD > W_TO) ? W_PD : W_TO;
   localparam int W_B   = (W_ST > W_SG) ? W_ST : W_SG;
   localparam int TMR_W = (W_A > W_B) ? W_A : W_B;
   localparam int RTY_W = $clog2(MAX_RETRIES + 1);
   localparam int CH_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic [TMR_W-1:0] PD_LAST   = TMR_W'(POWERDOWN_CYCLES - 1);
   localparam logic [TMR_W-1:0] TO_LAST   = TMR_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [TMR_W-1:0] ST_LAST   = TMR_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [TMR_W-1:0] SG_LAST   = TMR_W'(RST_STAGGER_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_LIMIT = RTY_W'(MAX_RETRIES);
   localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_OUT - 1);

   logic             sync1_q, lock_s_q;
   state_t           state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [CH_W-1:0]  chan_q, chan_d;
   logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
   logic             pd_n_q, pd_n_d;
   logic [N_OUT-1:0] out_q, out_d;
   logic             ready_q, ready_d;
   logic             fault_q, fault_d;
   logic [7:0]       loss_q, loss_d;

   assign retry_inc = retry_q + RTY_W'(1);

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      chan_d  = chan_q;
      retry_d = retry_q;
      out_d   = out_q;
      loss_d  = loss_q;

      if (!enable) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_d = S_PWRDN;
               timer_d = '0;
               retry_d = '0;
            end
            S_PWRDN: begin
               if (timer_q == PD_LAST) begin
                  state_d = S_WAIT;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_WAIT: begin
               if (lock_s_q) begin
                  state_d = S_STABLE;
                  timer_d = '0;
               end else if (timer_q == TO_LAST) begin
                  retry_d = retry_inc;
                  timer_d = '0;
                  state_d = (retry_inc == RTY_LIMIT) ? S_FAULT : S_PWRDN;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_STABLE: begin
               // A lock glitch here is not a loss event: just restart qualification.
               if (!lock_s_q) begin
                  state_d = S_WAIT;
                  timer_d = '0;
               end else if (timer_q == ST_LAST) begin
                  state_d = S_RELEASE;
                  timer_d = '0;
                  chan_d  = '0;
               end else begin
                  timer_d = timer_q + TMR_W'(1);
               end
            end
            S_RELEASE, S_RUN: begin
               if (!lock_s_q) begin
                  state_d = S_PWRDN;
                  timer_d = '0;
                  retry_d = '0;
                  if (loss_q != 8'hFF) begin
                     loss_d = loss_q + 8'd1;
                  end
               end else if (state_q == S_RELEASE) begin
                  // timer counts down the gap to the next channel release
                  if (timer_q == '0) begin
                     out_d[chan_q] = 1'b1;
                     if (chan_q == CH_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                     end else begin
                        chan_d  = chan_q + CH_W'(1);
                        timer_d = SG_LAST;
                     end
                  end else begin
                     timer_d = timer_q - TMR_W'(1);
                  end
               end
            end
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_IDLE;
         endcase
      end

      pd_n_d  = (state_d inside {S_WAIT, S_STABLE, S_RELEASE, S_RUN});
      ready_d = (state_d == S_RUN);
      fault_d = (state_d == S_FAULT);
      if (!(state_d inside {S_RELEASE, S_RUN})) begin
         out_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
         state_q  <= S_IDLE;
         timer_q  <= '0;
         chan_q   <= '0;
         retry_q  <= '0;
         pd_n_q   <= 1'b0;
         out_q    <= '0;
         ready_q  <= 1'b0;
         fault_q  <= 1'b0;
         loss_q   <= 8'd0;
      end else begin
         sync1_q  <= pll_lock;
         lock_s_q <= sync1_q;
         state_q  <= state_d;
         timer_q  <= timer_d;
         chan_q   <= chan_d;
         retry_q  <= retry_d;
         pd_n_q   <= pd_n_d;
         out_q    <= out_d;
         ready_q  <= ready_d;
         fault_q  <= fault_d;
         loss_q   <= loss_d;
      end
   end

   assign pll_powerdown_n = pd_n_q;
   assign out_reset_n     = out_q;
   assign ready           = ready_q;
   assign fault           = fault_q;
   assign lock_loss_count = loss_q;
   assign state           = state_q;

endmodule
`default_nettype wire
